// File: rtl/fpu_dma_initiator.sv
// FPU-side DMA initiator: takes a job from FPU control, requests the DMA
// controller, and buffers cache lines through read/write line FIFOs.
module fpu_dma_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_W     = 512,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_addr,
  input  logic [CNT_W-1:0]      job_lines,
  input  logic                  job_wr,
  output logic                  job_done,
  output logic                  job_err,
  output logic                  request,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [CNT_W-1:0]      request_size,
  output logic                  rd_wr,
  output logic                  fpu_ready,
  output logic [LINE_W-1:0]     write_data,
  input  logic [LINE_W-1:0]     read_data,
  input  logic                  dram_ready,
  input  logic                  request_done,
  input  logic                  line_taken,
  output logic                  rd_line_valid,
  input  logic                  rd_line_ready,
  output logic [LINE_W-1:0]     rd_line_data,
  input  logic                  wr_line_valid,
  output logic                  wr_line_ready,
  input  logic [LINE_W-1:0]     wr_line_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [LINE_W-1:0] rd_mem [DEPTH];
  logic [LINE_W-1:0] wr_mem [DEPTH];
  logic [PW-1:0]     rd_wp, rd_rp;
  logic [PW-1:0]     wr_wp, wr_rp;
  logic [PW:0]       rd_cnt, wr_cnt;

  logic accept, in_xfer;
  logic rd_take, rd_push, rd_drop, rd_pop;
  logic wr_push, wr_pop;

  assign job_ready = (state == S_IDLE);
  assign accept    = job_valid & job_ready;
  assign in_xfer   = (state == S_XFER);
  assign request   = (state == S_REQ) && (request_size != '0);
  assign job_done  = (state == S_FIN);

  always_comb begin
    fpu_ready = 1'b0;
    if (in_xfer) begin
      if (rd_wr) fpu_ready = (wr_cnt != '0) && (line_cnt < request_size);
      else       fpu_ready = (rd_cnt < FULL);
    end
  end

  // A read line past the job length is consumed but never stored.
  assign rd_take = in_xfer & ~rd_wr & dram_ready & fpu_ready;
  assign rd_push = rd_take & (line_cnt != request_size);
  assign rd_drop = rd_take & (line_cnt == request_size);
  assign wr_pop  = in_xfer & rd_wr & line_taken & fpu_ready;
  assign cnt_nxt = line_cnt + CNT_W'(rd_push | wr_pop);

  assign rd_line_valid = (rd_cnt != '0);
  assign rd_pop        = rd_line_valid & rd_line_ready;
  assign rd_line_data  = rd_line_valid ? rd_mem[rd_rp] : '0;

  assign wr_line_ready = (wr_cnt != FULL);
  assign wr_push       = wr_line_valid & wr_line_ready;
  assign write_data    = (wr_cnt != '0) ? wr_mem[wr_rp] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      address      <= '0;
      request_size <= '0;
      rd_wr        <= 1'b0;
      line_cnt     <= '0;
      job_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          address      <= job_addr;
          request_size <= job_lines;
          rd_wr        <= job_wr;
          line_cnt     <= '0;
          job_err      <= 1'b0;
          state        <= S_REQ;
        end
        // A zero-line job uses its request slot silently, then finishes.
        S_REQ: state <= (request_size == '0) ? S_FIN : S_XFER;
        S_XFER: begin
          line_cnt <= cnt_nxt;
          if (rd_drop) job_err <= 1'b1;
          if (request_done) begin
            state <= S_FIN;
            if (cnt_nxt != request_size) job_err <= 1'b1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wp  <= '0;
      rd_rp  <= '0;
      rd_cnt <= '0;
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_push) rd_wp <= rd_wp + 1'b1;
      if (rd_pop)  rd_rp <= rd_rp + 1'b1;
      rd_cnt <= rd_cnt + (PW+1)'(rd_push) - (PW+1)'(rd_pop);
      if (wr_push) wr_wp <= wr_wp + 1'b1;
      if (wr_pop)  wr_rp <= wr_rp + 1'b1;
      wr_cnt <= wr_cnt + (PW+1)'(wr_push) - (PW+1)'(wr_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wp] <= read_data;
    if (wr_push) wr_mem[wr_wp] <= wr_line_data;
  end

endmodule

// File: tb/tb_fpu_dma_initiator.sv
// Directed/randomized bench for fpu_dma_initiator against a queue-based
// model of the line FIFOs and job bookkeeping.
module tb_fpu_dma_initiator;

  localparam int AW     = 32;
  localparam int LINE_W = 512;
  localparam int DEPTH  = 4;
  localparam int CW     = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              job_valid, job_wr;
  logic [AW-1:0]     job_addr;
  logic [CW-1:0]     job_lines;
  logic              job_ready, job_done, job_err;
  logic              request, rd_wr, fpu_ready;
  logic [AW-1:0]     address;
  logic [CW-1:0]     request_size;
  logic [LINE_W-1:0] write_data, read_data;
  logic              dram_ready, request_done, line_taken;
  logic              rd_line_valid, rd_line_ready;
  logic [LINE_W-1:0] rd_line_data;
  logic              wr_line_valid, wr_line_ready;
  logic [LINE_W-1:0] wr_line_data;

  fpu_dma_initiator #(
    .ADDR_WIDTH(AW), .LINE_W(LINE_W), .DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_addr(job_addr), .job_lines(job_lines), .job_wr(job_wr),
    .job_done(job_done), .job_err(job_err),
    .request(request), .address(address),
    .request_size(request_size), .rd_wr(rd_wr),
    .fpu_ready(fpu_ready), .write_data(write_data),
    .read_data(read_data), .dram_ready(dram_ready),
    .request_done(request_done), .line_taken(line_taken),
    .rd_line_valid(rd_line_valid), .rd_line_ready(rd_line_ready),
    .rd_line_data(rd_line_data),
    .wr_line_valid(wr_line_valid), .wr_line_ready(wr_line_ready),
    .wr_line_data(wr_line_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [LINE_W-1:0] rdq[$];
  logic [LINE_W-1:0] wrq[$];
  bit xfer_rd, xfer_wr, merr;
  int mcnt, mlines;

  function automatic logic [LINE_W-1:0] rline();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, apply this cycle's inputs, advance.
  task automatic step();
    bit er, ew;
    int rn, wn;
    rn = rdq.size();
    wn = wrq.size();
    er = xfer_rd && rn < DEPTH;
    ew = xfer_wr && wn > 0 && mcnt < mlines;
    chk("fpu_ready", fpu_ready, er | ew);
    chk("rd_line_valid", rd_line_valid, rn > 0);
    chk("rd_line_data", rd_line_data, rn > 0 ? rdq[0] : '0);
    chk("wr_line_ready", wr_line_ready, wn < DEPTH);
    chk("write_data", write_data, wn > 0 ? wrq[0] : '0);
    chk("job_err", job_err, merr);
    if (rd_line_ready && rn > 0) void'(rdq.pop_front());
    if (er && dram_ready) begin
      if (mcnt < mlines) begin
        rdq.push_back(read_data);
        mcnt++;
      end else merr = 1;
    end
    if (ew && line_taken) begin
      void'(wrq.pop_front());
      mcnt++;
    end
    if (wr_line_valid && wn < DEPTH) wrq.push_back(wr_line_data);
    if (request_done && (xfer_rd || xfer_wr)) begin
      if (mcnt != mlines) merr = 1;
      xfer_rd = 0;
      xfer_wr = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [AW-1:0] a, input int n, input bit w);
    chk("job_ready_idle", job_ready, 1'b1);
    job_valid = 1;
    job_addr  = a;
    job_lines = CW'(n);
    job_wr    = w;
    step();
    job_valid = 0;
    merr = 0;
    mcnt = 0;
    mlines = n;
    chk("request", request, n != 0);
    chk("address", address, a);
    chk("request_size", request_size, n);
    chk("rd_wr", rd_wr, w);
    chk("job_ready_busy", job_ready, 1'b0);
    step();
    chk("request_pulse", request, 1'b0);
    if (n != 0) begin
      xfer_rd = !w;
      xfer_wr = w;
    end else begin
      chk("job_done_zero", job_done, 1'b1);
      step();
      chk("job_done_zero_end", job_done, 1'b0);
    end
  endtask

  task automatic finish_job();
    request_done = 1;
    step();
    request_done = 0;
    chk("job_done", job_done, 1'b1);
    chk("job_err_done", job_err, merr);
    chk("fpu_ready_fin", fpu_ready, 1'b0);
    step();
    chk("job_done_pulse", job_done, 1'b0);
    chk("job_ready_back", job_ready, 1'b1);
  endtask

  task automatic deliver(input int target, input bit rnd);
    int n = 0;
    while (mcnt < target && n < 60) begin
      read_data  = rline();
      dram_ready = rnd ? 1'($urandom % 2) : 1'b1;
      step();
      n++;
    end
    dram_ready = 0;
    chk("deliver_count", mcnt, target);
  endtask

  task automatic drain();
    int n = 0;
    while (rdq.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", rdq.size(), 0);
  endtask

  initial begin
    rst_n = 0;
    job_valid = 0; job_addr = '0; job_lines = '0; job_wr = 0;
    read_data = '0; dram_ready = 0; request_done = 0; line_taken = 0;
    rd_line_ready = 0; wr_line_valid = 0; wr_line_data = '0;
    xfer_rd = 0; xfer_wr = 0; merr = 0; mcnt = 0; mlines = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_request", request, 1'b0);
    chk("rst_fpu_ready", fpu_ready, 1'b0);
    chk("rst_job_done", job_done, 1'b0);
    chk("rst_address", address, '0);
    chk("rst_size", request_size, '0);
    chk("rst_rd_valid", rd_line_valid, 1'b0);
    rst_n = 1;
    step();

    // Read 3 lines, consumer always ready, irregular line arrival.
    rd_line_ready = 1;
    run_job(32'h1000, 3, 0);
    deliver(3, 1);
    drain();
    finish_job();

    // Read 6 lines into a 4-deep FIFO with a stalled consumer.
    rd_line_ready = 0;
    run_job(32'h2000, 6, 0);
    for (int i = 0; i < 6; i++) begin
      read_data  = rline();
      dram_ready = 1;
      step();
    end
    chk("rd_full_cnt", mcnt, DEPTH);
    rd_line_ready = 1;
    deliver(6, 0);
    drain();
    finish_job();

    // Overrun: one extra line past the job length.
    run_job(32'h3000, 1, 0);
    for (int i = 0; i < 2; i++) begin
      read_data  = rline();
      dram_ready = 1;
      step();
    end
    dram_ready = 0;
    chk("overrun_err", job_err, 1'b1);
    drain();
    finish_job();

    // Short job: done after 1 of 2 lines.
    run_job(32'h4000, 2, 0);
    deliver(1, 0);
    drain();
    finish_job();
    chk("short_err", job_err, 1'b1);

    // Write 2 lines from a pre-loaded FIFO holding three.
    wr_line_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_line_data = rline();
      step();
    end
    wr_line_valid = 0;
    run_job(32'h5000, 2, 1);
    line_taken = 1;
    repeat (4) step();
    line_taken = 0;
    chk("wr_taken", mcnt, 2);
    chk("wr_left", wrq.size(), 1);
    finish_job();

    // Fill write FIFO to full, then a zero-line job.
    wr_line_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr_line_data = rline();
      step();
    end
    wr_line_valid = 0;
    chk("wr_full", wr_line_ready, 1'b0);
    run_job(32'h6000, 0, 0);
    step();

    // Asynchronous reset mid-transfer with two lines buffered.
    rd_line_ready = 0;
    run_job(32'h7000, 4, 0);
    deliver(2, 0);
    chk("pre_rst_valid", rd_line_valid, 1'b1);
    #3 rst_n = 0;
    #1;
    chk("arst_rd_valid", rd_line_valid, 1'b0);
    chk("arst_fpu_ready", fpu_ready, 1'b0);
    chk("arst_request", request, 1'b0);
    chk("arst_job_ready", job_ready, 1'b1);
    chk("arst_wr_ready", wr_line_ready, 1'b1);
    chk("arst_write_data", write_data, '0);
    rdq.delete();
    wrq.delete();
    xfer_rd = 0; xfer_wr = 0; merr = 0; mcnt = 0; mlines = 0;
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;

    rd_line_ready = 1;
    run_job(32'h8000, 2, 0);
    deliver(2, 1);
    drain();
    finish_job();
    chk("final_err", job_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
